// File: rtl/bbox_tracker_pkg.sv
// bbox_tracker_pkg: shared widths, default frame geometry and the box record
package bbox_tracker_pkg;
  localparam int COORD_W = 10;
  localparam int CNT_W = 20;
  localparam int DEF_IMG_WIDTH = 768;
  localparam int DEF_IMG_HEIGHT = 576;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
    logic valid;
  } bbox_t;
endpackage

// File: rtl/bbox_tracker_raster_pos_cnt.sv
// raster_pos_cnt: raster column/row counters with clear and last-pixel flag
module raster_pos_cnt
  import bbox_tracker_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic last
);
  localparam logic [COORD_W-1:0] MAXC = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] MAXR = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  assign last = col == MAXC && row == MAXR;
  // a clear with a pixel present consumes (0,0), so the next position is column 1
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= COORD_W'(en);
      row <= '0;
    end else if (en) begin
      col <= col == MAXC ? '0 : col + ONE;
      row <= col == MAXC ? (row == MAXR ? '0 : row + ONE) : row;
    end
  end
endmodule

// File: rtl/bbox_tracker.sv
// bbox_tracker: per-frame min/max of set mask pixels, published as centre and
// extent at end of frame and held until the next publish
module bbox_tracker
  import bbox_tracker_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int MIN_PIXELS = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  input  logic in_valid,
  input  logic mask,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] width,
  output logic [COORD_W-1:0] height,
  output logic bbox_valid,
  output logic frame_done
);
  localparam logic [COORD_W-1:0] MAXC = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] MAXR = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);
  logic [COORD_W-1:0] col, row, px, py;
  logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
  logic [COORD_W-1:0] bmin_x, bmax_x, bmin_y, bmax_y;
  logic [COORD_W-1:0] nmin_x, nmax_x, nmin_y, nmax_y;
  logic [CNT_W-1:0] cnt, bcnt, ncnt;
  logic [COORD_W:0] sx, sy;
  logic last, hit, eop;
  raster_pos_cnt #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_pos (
    .clk(clk), .reset(reset), .clr(frame_start), .en(in_valid),
    .col(col), .row(row), .last(last)
  );
  // frame_start folds the accumulator clear into this cycle's pixel
  assign px = frame_start ? '0 : col;
  assign py = frame_start ? '0 : row;
  assign bmin_x = frame_start ? MAXC : min_x;
  assign bmax_x = frame_start ? '0 : max_x;
  assign bmin_y = frame_start ? MAXR : min_y;
  assign bmax_y = frame_start ? '0 : max_y;
  assign bcnt = frame_start ? '0 : cnt;
  assign hit = in_valid & mask;
  assign nmin_x = hit && px < bmin_x ? px : bmin_x;
  assign nmax_x = hit && px > bmax_x ? px : bmax_x;
  assign nmin_y = hit && py < bmin_y ? py : bmin_y;
  assign nmax_y = hit && py > bmax_y ? py : bmax_y;
  assign ncnt = hit && ~&bcnt ? bcnt + CNT_ONE : bcnt;
  assign eop = in_valid & ~frame_start & last;
  assign sx = {1'b0, nmin_x} + {1'b0, nmax_x};
  assign sy = {1'b0, nmin_y} + {1'b0, nmax_y};
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
      width <= '0;
      height <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
      min_x <= MAXC;
      max_x <= '0;
      min_y <= MAXR;
      max_y <= '0;
      cnt <= '0;
    end else begin
      frame_done <= eop;
      min_x <= eop ? MAXC : nmin_x;
      max_x <= eop ? '0 : nmax_x;
      min_y <= eop ? MAXR : nmin_y;
      max_y <= eop ? '0 : nmax_y;
      cnt <= eop ? '0 : ncnt;
      if (eop) bbox_valid <= ncnt >= CNT_MIN;
      if (eop && ncnt >= CNT_MIN) begin
        x <= sx[COORD_W:1];
        y <= sy[COORD_W:1];
        width <= nmax_x - nmin_x + ONE;
        height <= nmax_y - nmin_y + ONE;
      end
    end
  end
endmodule
